sync_filt: RTL and testbench

- Multi-channel clock-domain-crossing synchroniser with a configurable number of flop stages per channel.
- Each synchronised channel feeds a per-channel stability (glitch/debounce) filter and a registered rise/fall edge detector.
- Used wherever asynchronous levels (buttons, external status pins, slow cross-domain flags) enter the clk domain and need clean levels plus single-cycle event pulses.

---
 rtl/sync_filt.sv | 125 ++++++++++++
 tb/tb_sync_filt.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_filt.sv
// rtl/sync_filt.sv - multi-channel CDC synchroniser with stability filter and edge pulses
//
// Purpose:
//   Brings NUM_CH asynchronous levels into the clk domain through a
//   SYNC_STAGES-deep flop chain per channel. Each synchronised level is then
//   qualified by a stability filter: a new value must be seen for FILT_CNT
//   consecutive cycles before it is accepted. Registered one-cycle rise/fall
//   pulses accompany every accepted change.
//
// Ports:
//   clk          in   1       single clock, posedge
//   rst_n        in   1       asynchronous active-low reset
//   async_in     in   NUM_CH  asynchronous inputs, bit i = channel i
//   filt_bypass  in   1       1 = accept the synchronised value every cycle
//   sync_out     out  NUM_CH  filtered synchronised level
//   rise_pls     out  NUM_CH  one-cycle pulse on sync_out 0->1
//   fall_pls     out  NUM_CH  one-cycle pulse on sync_out 1->0
//   pend         out  NUM_CH  channel filter counter is non-zero

module sync_filt #(
  parameter int                NUM_CH      = 4,
  parameter int                SYNC_STAGES = 2,
  parameter int                FILT_CNT    = 4,
  parameter logic [NUM_CH-1:0] RST_VAL     = {NUM_CH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] async_in,
  input  logic              filt_bypass,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] rise_pls,
  output logic [NUM_CH-1:0] fall_pls,
  output logic [NUM_CH-1:0] pend
);

  localparam int              CW      = $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(FILT_CNT - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser chain: plain flop-to-flop, no logic between stages.
  // ---------------------------------------------------------------------------
  (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = async_in;
    for (int n = 1; n < SYNC_STAGES; n++) begin
      sync_d[n] = sync_q[n-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < SYNC_STAGES; n++) begin
        sync_q[n] <= RST_VAL;
      end
    end else begin
      for (int n = 0; n < SYNC_STAGES; n++) begin
        sync_q[n] <= sync_d[n];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stability filter, edge detector and pending flag.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] s;
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];
  logic [NUM_CH-1:0] level_q, level_d;
  logic [NUM_CH-1:0] rise_q,  rise_d;
  logic [NUM_CH-1:0] fall_q,  fall_d;
  logic [NUM_CH-1:0] pend_q,  pend_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d = level_q;
    pend_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (filt_bypass) begin
        level_d[i] = s[i];
      end else if (s[i] != level_q[i]) begin
        // The counter holds the number of differing cycles already seen, so
        // the FILT_CNT-th differing cycle is the one that finds CNT_MAX.
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
      pend_d[i] = (cnt_d[i] != '0);
    end
    // Pulses are computed from the next level so they appear together with it.
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= RST_VAL;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
    end
  end

  assign sync_out = level_q;
  assign rise_pls = rise_q;
  assign fall_pls = fall_q;
  assign pend     = pend_q;

endmodule

// File: tb/tb_sync_filt.sv
// tb/tb_sync_filt.sv - self-checking bench for sync_filt

module tb_sync_filt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ain0, ain1;
  logic       byp0, byp1, byp2;
  logic [0:0] ain2;
  logic [3:0] so0, ri0, fa0, pe0;
  logic [3:0] so1, ri1, fa1, pe1;
  logic [0:0] so2, ri2, fa2, pe2;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_filt u0 (
    .clk(clk), .rst_n(rst_n), .async_in(ain0), .filt_bypass(byp0),
    .sync_out(so0), .rise_pls(ri0), .fall_pls(fa0), .pend(pe0)
  );

  sync_filt #(.RST_VAL(4'hF)) u1 (
    .clk(clk), .rst_n(rst_n), .async_in(ain1), .filt_bypass(byp1),
    .sync_out(so1), .rise_pls(ri1), .fall_pls(fa1), .pend(pe1)
  );

  sync_filt #(.NUM_CH(1), .SYNC_STAGES(3), .FILT_CNT(1), .RST_VAL(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .async_in(ain2), .filt_bypass(byp2),
    .sync_out(so2), .rise_pls(ri2), .fall_pls(fa2), .pend(pe2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: input history queue models the synchroniser delay, a
  // run-length of consecutive differing samples models the filter.
  // ---------------------------------------------------------------------------
  logic [3:0] m_hist [2][$];
  logic [3:0] m_out  [2];
  int         m_run  [2][4];

  task automatic model_reset(input int id, input int ss, input logic [3:0] rv);
    m_hist[id].delete();
    for (int k = 0; k < ss; k++) m_hist[id].push_back(rv);
    m_out[id] = rv;
    for (int c = 0; c < 4; c++) m_run[id][c] = 0;
  endtask

  task automatic model_step(input int id, input int fc, input int nch,
                            input logic [3:0] ain, input logic byp,
                            output logic [15:0] exp);
    logic [3:0] s, nout, pe;
    s = m_hist[id].pop_front();
    m_hist[id].push_back(ain);
    nout = m_out[id];
    pe   = '0;
    for (int c = 0; c < nch; c++) begin
      if (byp) begin
        nout[c] = s[c];
        m_run[id][c] = 0;
      end else if (s[c] != m_out[id][c]) begin
        m_run[id][c]++;
        if (m_run[id][c] == fc) begin
          nout[c] = s[c];
          m_run[id][c] = 0;
        end
      end else begin
        m_run[id][c] = 0;
      end
      pe[c] = (m_run[id][c] != 0);
    end
    exp = {nout, nout & ~m_out[id], ~nout & m_out[id], pe};
    m_out[id] = nout;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ain0 = 4'h0; ain1 = 4'hF; ain2 = 1'b0;
    byp0 = 1'b0; byp1 = 1'b0; byp2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] ain;
    logic [3:0] so, ri, fa, pe;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(logic [3:0] a, logic [3:0] so, logic [3:0] ri,
                              logic [3:0] fa, logic [3:0] pe);
    vec_t v;
    v.ain = a; v.so = so; v.ri = ri; v.fa = fa; v.pe = pe;
    return v;
  endfunction

  initial begin
    logic [15:0] e0, e2;
    int          hold;

    // Rise on ch0, glitch on ch1, fall on ch0, simultaneous rise on all.
    //              ain   so    ri    fa    pe
    vt.push_back(mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0));
    vt.push_back(mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0));
    vt.push_back(mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h1));
    vt.push_back(mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h1));
    vt.push_back(mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h1));
    vt.push_back(mk(4'h1, 4'h1, 4'h1, 4'h0, 4'h0));
    vt.push_back(mk(4'h1, 4'h1, 4'h0, 4'h0, 4'h0));
    vt.push_back(mk(4'h3, 4'h1, 4'h0, 4'h0, 4'h0));
    vt.push_back(mk(4'h3, 4'h1, 4'h0, 4'h0, 4'h0));
    vt.push_back(mk(4'h3, 4'h1, 4'h0, 4'h0, 4'h2));
    vt.push_back(mk(4'h1, 4'h1, 4'h0, 4'h0, 4'h2));
    vt.push_back(mk(4'h1, 4'h1, 4'h0, 4'h0, 4'h2));
    vt.push_back(mk(4'h1, 4'h1, 4'h0, 4'h0, 4'h0));
    vt.push_back(mk(4'h1, 4'h1, 4'h0, 4'h0, 4'h0));
    vt.push_back(mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h0));
    vt.push_back(mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h0));
    vt.push_back(mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h1));
    vt.push_back(mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h1));
    vt.push_back(mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h1));
    vt.push_back(mk(4'h0, 4'h0, 4'h0, 4'h1, 4'h0));
    vt.push_back(mk(4'hF, 4'h0, 4'h0, 4'h0, 4'h0));
    vt.push_back(mk(4'hF, 4'h0, 4'h0, 4'h0, 4'h0));
    vt.push_back(mk(4'hF, 4'h0, 4'h0, 4'h0, 4'hF));
    vt.push_back(mk(4'hF, 4'h0, 4'h0, 4'h0, 4'hF));
    vt.push_back(mk(4'hF, 4'h0, 4'h0, 4'h0, 4'hF));
    vt.push_back(mk(4'hF, 4'hF, 4'hF, 4'h0, 4'h0));
    vt.push_back(mk(4'hF, 4'hF, 4'h0, 4'h0, 4'h0));

    // Reset state.
    rst_n = 1'b0;
    ain0 = 4'h0; ain1 = 4'hF; ain2 = 1'b0;
    byp0 = 1'b0; byp1 = 1'b0; byp2 = 1'b0;
    #12;
    chk("rst.u0", {so0, ri0, fa0, pe0}, 16'h0000);
    chk("rst.u1", {so1, ri1, fa1, pe1}, 16'hF000);
    chk("rst.u2", {so2, ri2, fa2, pe2}, 4'h0);

    // Table-driven sequence on u0.
    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      ain0 = vt[i].ain;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.so", i), so0, vt[i].so);
      chk($sformatf("vec%0d.ri", i), ri0, vt[i].ri);
      chk($sformatf("vec%0d.fa", i), fa0, vt[i].fa);
      chk($sformatf("vec%0d.pe", i), pe0, vt[i].pe);
    end

    // Bypass on u1 (RST_VAL=F): ch2 falls at edge 3, pend stays 0.
    do_reset();
    byp1 = 1'b1;
    ain1 = 4'hB;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("byp.so%0d", k), so1, (k >= 3) ? 4'hB : 4'hF);
      chk($sformatf("byp.fa%0d", k), fa1, (k == 3) ? 4'h4 : 4'h0);
      chk($sformatf("byp.ri%0d", k), ri1, 4'h0);
      chk($sformatf("byp.pe%0d", k), pe1, 4'h0);
    end

    // Reset in the middle of a ch0 qualification on u0.
    do_reset();
    ain0 = 4'h1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid.pe_before", pe0, 4'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid.rst_out", {so0, ri0, fa0, pe0}, 16'h0000);
    @(posedge clk); #1;
    chk("mid.rst_hold", {so0, ri0, fa0, pe0}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mid.so%0d", k), so0, (k >= 6) ? 4'h1 : 4'h0);
      chk($sformatf("mid.ri%0d", k), ri0, (k == 6) ? 4'h1 : 4'h0);
      chk($sformatf("mid.pe%0d", k), pe0, (k >= 3 && k <= 5) ? 4'h1 : 4'h0);
    end

    // SYNC_STAGES=3, FILT_CNT=1 on u2: change visible at edge 4.
    do_reset();
    ain2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("u2.so%0d", k), so2, (k >= 4) ? 1 : 0);
      chk($sformatf("u2.ri%0d", k), ri2, (k == 4) ? 1 : 0);
      chk($sformatf("u2.pe%0d", k), pe2, 0);
    end

    // Randomised run against the reference model (u0 and u2).
    do_reset();
    model_reset(0, 2, 4'h0);
    model_reset(1, 3, 4'h0);
    hold = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (hold == 0) begin
        ain0 = 4'($urandom);
        hold = $urandom_range(1, 7);
      end
      hold--;
      if ($urandom_range(0, 9) == 0) ain0[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) byp0 = ~byp0;
      if ($urandom_range(0, 2) == 0) ain2 = ~ain2;
      if ($urandom_range(0, 15) == 0) byp2 = ~byp2;
      @(posedge clk); #1;
      model_step(0, 4, 4, ain0, byp0, e0);
      model_step(1, 1, 1, {3'b000, ain2}, byp2, e2);
      chk($sformatf("rnd0.%0d", cyc), {so0, ri0, fa0, pe0}, e0);
      chk($sformatf("rnd2.%0d", cyc), {so2, ri2, fa2, pe2},
          {e2[12], e2[8], e2[4], e2[0]});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
